dcache_2way_wb: RTL and testbench
=================================

# dcache_2way_wb

Two-way set-associative, write-back, write-allocate data cache between the core's load/store port and the line-wide data memory. It is the parametrised successor of the direct-mapped data cache. Line width, set count and address width are configurable. Per-set LRU replacement and saturating hit/miss counters are added. Tag, valid, dirty and data arrays are internal registers with combinational read, so a hit is served in the request cycle.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- LINE_W, 256, line width in bits; power of two, at least 64
- SETS, 16, number of sets; power of two, at least 2
- CNT_W, 16, width of the performance counters
- Derived: OFF_W = log2(LINE_W/8); IDX_W = log2(SETS); TAG_W = ADDR_W-IDX_W-OFF_W; word size fixed at 32 bits

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- p1_addr_i  in  ADDR_W  byte address; index = [OFF_W+IDX_W-1:OFF_W], word select = [OFF_W-1:2], bits [1:0] ignored
- p1_data_i  in  32  store data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request; wins if both requests are high
- p1_data_o  out  32  load data; hit-way word when hit, else 0
- p1_stall_o  out  1  core must hold the request stable while this is high
- mem_enable_o  out  1  memory request, registered
- mem_write_o  out  1  1 = write-back of a line, 0 = fill, registered
- mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits 0), registered
- mem_data_o  out  LINE_W  victim line data, registered at write-back start
- mem_data_i  in  LINE_W  fill data, valid when mem_ack_i = 1
- mem_ack_i  in  1  single-cycle completion pulse
- hit_cnt_o  out  CNT_W  saturating count of served hits
- miss_cnt_o  out  CNT_W  saturating count of misses

## Operation
- Per set: two ways, each holding valid, dirty, tag and a line, plus one LRU bit giving the way to replace next.
- Hit: state IDLE, request active, and some way is valid with a matching tag. Both ways matching cannot occur.
- Read hit: p1_data_o is the selected word of the hit way, combinationally. At the clock edge, LRU is set to the other way and hit_cnt increments.
- Write hit: at the edge, the selected 32-bit word of the hit way is replaced by p1_data_i, dirty is set to 1, LRU is set to the other way, and hit_cnt increments.
- Victim selection: way0 if way0 is invalid; otherwise way1 if way1 is invalid; otherwise the way named by LRU. The victim is latched on the miss-detection edge.
- States:
  - IDLE
    - request with no hit -> miss_cnt++; if the victim is valid and dirty -> WB, else -> FILL.
    - on entry to WB: mem_enable=1, mem_write=1, mem_addr={victim tag, index, 0}, mem_data=victim line.
    - on entry to FILL: mem_enable=1, mem_write=0, mem_addr={req tag, index, 0}.
  - WB
    - on mem_ack_i -> FILL; mem_write=0 and mem_addr=request line, with mem_enable held at 1.
    - otherwise stay in WB.
  - FILL
    - on mem_ack_i: the victim way is written with mem_data_i, valid=1, dirty=0, tag=request tag; mem_enable=0; -> DONE.
    - otherwise stay in FILL.
  - DONE
    - one cycle, then -> IDLE.
    - The request is then re-evaluated as a hit; a store completes at that point as a write hit.
- p1_stall_o = (state != IDLE) | (request & ~hit).
- Counters saturate at all-ones. A miss counts once, and its later hit in IDLE also counts as a hit.

## Timing
- Hit: 0-cycle latency, no stall.
- Clean miss with memory latency L (cycles from request to ack): stall for 1 (IDLE) + L (FILL) + 1 (DONE) cycles, then served.
- Dirty miss adds the write-back latency.
- mem_enable_o stays high continuously from the miss edge until the fill-ack edge. The address changes only on the WB ack.
- mem_ack_i is ignored in IDLE and DONE.
- Reset, including mid-miss: state=IDLE; all valid, dirty and LRU bits = 0; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; counters=0. An outstanding memory transaction is abandoned.
- Data arrays need no reset.
- Array writes take effect at the edge and are visible combinationally in the next cycle.

## Test plan
- Reset, then a load from 0x0000_0040 with memory L=3 returning a line whose word1 = 0xDEADBEEF:
  - required: stall for 5 cycles, mem_addr_o=0x40, mem_write_o=0;
  - then p1_data_o=0xDEADBEEF, miss_cnt=1, hit_cnt=1.
- Store 0x12345678 to 0x44 (a hit), then a load from 0x44:
  - required: no stall, load returns 0x12345678, that way's dirty=1.
- Same index, tags A, B, C (A dirty, B more recently used):
  - required: C evicts A with a write-back to A's line address carrying the modified data, then a fill of C;
  - then a load of B hits.
- Conflict pair A/B alternating 10 times after both are filled:
  - required: no further misses;
  - LRU toggles every access.
- Assert rst_i low during FILL:
  - required: mem_enable_o drops immediately and p1_stall_o=0 with no request;
  - the next load of the same address misses.
- Drive 2^CNT_W+5 hits with CNT_W=4:
  - required: hit_cnt_o holds at 0xF.

Source files
------------

// File: rtl/dcache_2way_wb.sv
// rtl/dcache_2way_wb.sv - two-way set-associative write-back, write-allocate data cache
//
// Ports:
//   clk_i, rst_i                  clock (rising edge), asynchronous active-low reset
//   p1_addr_i, p1_data_i          core byte address and store data
//   p1_MemRead_i, p1_MemWrite_i   load / store request (store wins when both are high)
//   p1_data_o, p1_stall_o         load data (hit-way word on a hit, else 0) and stall
//   mem_enable_o, mem_write_o     registered line-memory request and direction
//   mem_addr_o, mem_data_o        registered line-aligned address and write-back data
//   mem_data_i, mem_ack_i         fill data and single-cycle completion pulse
//   hit_cnt_o, miss_cnt_o         saturating hit / miss counters

module dcache_2way_wb #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Request decode
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic              req;
  logic              addr_lsb_unused;

  assign req_idx         = p1_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign req_tag         = p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign req_wsel        = p1_addr_i[OFF_W-1:2];
  assign req             = p1_MemRead_i | p1_MemWrite_i;
  assign addr_lsb_unused = ^p1_addr_i[1:0];

  // Storage: metadata is reset, tag/data arrays are not
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [2][SETS];
  logic [LINE_W-1:0] data_q  [2][SETS];

  // Control state
  state_t            state_q, state_d;
  logic              victim_q, victim_d;
  logic [IDX_W-1:0]  midx_q, midx_d;
  logic [TAG_W-1:0]  mtag_q, mtag_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  // Lookup
  logic              hit0, hit1, hit, miss, hit_way;
  logic [LINE_W-1:0] hit_line, merged_line, victim_line;
  logic [31:0]       hit_word;
  logic              victim_sel, victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              fill_ack;

  assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit     = (state_q == S_IDLE) && req && (hit0 || hit1);
  assign miss    = (state_q == S_IDLE) && req && !(hit0 || hit1);
  assign hit_way = hit1;

  assign hit_line = hit_way ? data_q[1][req_idx] : data_q[0][req_idx];
  assign hit_word = hit_line[{req_wsel, 5'b00000} +: 32];

  always_comb begin
    merged_line = hit_line;
    merged_line[{req_wsel, 5'b00000} +: 32] = p1_data_i;
  end

  // Invalid ways are filled first; only a full set consults LRU
  assign victim_sel   = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx];
  assign victim_tag   = tag_q[victim_sel][req_idx];
  assign victim_line  = data_q[victim_sel][req_idx];

  assign fill_ack = (state_q == S_FILL) && mem_ack_i;

  // FSM: state and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      victim_q     <= 1'b0;
      midx_q       <= '0;
      mtag_q       <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      midx_q       <= midx_d;
      mtag_q       <= mtag_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (miss) state_d = victim_dirty ? S_WB : S_FILL;
      S_WB:    if (mem_ack_i) state_d = S_FILL;
      S_FILL:  if (mem_ack_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and miss bookkeeping
  always_comb begin
    victim_d     = victim_q;
    midx_d       = midx_q;
    mtag_d       = mtag_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (miss) begin
          // The request line is latched so the fill lands where the miss was seen
          victim_d     = victim_sel;
          midx_d       = req_idx;
          mtag_d       = req_tag;
          mem_enable_d = 1'b1;
          if (victim_dirty) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {victim_tag, req_idx, {OFF_W{1'b0}}};
            mem_data_d  = victim_line;
          end else begin
            mem_write_d = 1'b0;
            mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
          end
        end
      end
      S_WB: begin
        // Enable stays high: the write-back flows straight into the fill
        if (mem_ack_i) begin
          mem_write_d = 1'b0;
          mem_addr_d  = {mtag_q, midx_q, {OFF_W{1'b0}}};
        end
      end
      S_FILL: begin
        if (mem_ack_i) mem_enable_d = 1'b0;
      end
      default: ;
    endcase

    if (hit && (hit_cnt_q != CNT_MAX))   hit_cnt_d  = hit_cnt_q + CNT_ONE;
    if (miss && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + CNT_ONE;
  end

  // Valid / dirty / LRU
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
    end else if (fill_ack) begin
      valid_q[victim_q][midx_q] <= 1'b1;
      dirty_q[victim_q][midx_q] <= 1'b0;
    end else if (hit) begin
      lru_q[req_idx] <= ~hit_way;
      if (p1_MemWrite_i) dirty_q[hit_way][req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk_i) begin
    if (fill_ack) begin
      data_q[victim_q][midx_q] <= mem_data_i;
      tag_q[victim_q][midx_q]  <= mtag_q;
    end else if (hit && p1_MemWrite_i) begin
      data_q[hit_way][req_idx] <= merged_line;
    end
  end

  assign p1_data_o    = hit ? hit_word : 32'h0;
  assign p1_stall_o   = (state_q != S_IDLE) || miss;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign hit_cnt_o    = hit_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_2way_wb.sv
// tb/tb_dcache_2way_wb.sv - scoreboard bench for dcache_2way_wb against a flat-memory LRU model

module tb_dcache_2way_wb;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int SETS   = 16;
  localparam int CNT_W  = 4;
  localparam int WORDS  = LINE_W / 32;
  localparam int LINE_B = LINE_W / 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [31:0]       p1_data_i;
  logic              p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [CNT_W-1:0]  hit_cnt_o, miss_cnt_o;

  always #5 clk_i = ~clk_i;

  dcache_2way_wb #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: flat word memories plus per-set recency lists
  logic [31:0] gmem [int unsigned];   // architectural view (all stores applied)
  logic [31:0] bmem [int unsigned];   // backing line memory
  int unsigned mru [SETS];
  int unsigned lru_l [SETS];
  bit          mru_v [SETS];
  bit          lru_v [SETS];
  bit          dirty_l [int unsigned];
  int          m_hits, m_miss;
  int          cur_lat;

  typedef struct { logic [31:0] data; int h; int m; } sb_t;
  typedef struct { int unsigned addr; logic [LINE_W-1:0] line; } wb_t;
  sb_t sbq [$];
  wb_t wbq [$];

  function automatic logic [31:0] init_word(input int unsigned wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] gword(input int unsigned wa);
    return gmem.exists(wa) ? gmem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] bword(input int unsigned wa);
    return bmem.exists(wa) ? bmem[wa] : init_word(wa);
  endfunction

  function automatic logic [LINE_W-1:0] gline(input int unsigned la);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < WORDS; k++) l[k*32 +: 32] = gword(la / 4 + k);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] bline(input int unsigned la);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < WORDS; k++) l[k*32 +: 32] = bword(la / 4 + k);
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mru_v[s] = 1'b0;
      lru_v[s] = 1'b0;
    end
    dirty_l.delete();
    gmem   = bmem;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic model_access(input int unsigned addr, input bit wr, input logic [31:0] data,
                              output int stall_exp);
    int unsigned la, s, wa, tmp;
    bit hit, wb;
    sb_t e;
    la = addr & ~(LINE_B - 1);
    s  = (addr / LINE_B) % SETS;
    wa = addr / 4;
    hit = (mru_v[s] && mru[s] == la) || (lru_v[s] && lru_l[s] == la);
    stall_exp = 0;
    if (hit) begin
      if (!(mru_v[s] && mru[s] == la)) begin
        tmp = mru[s]; mru[s] = lru_l[s]; lru_l[s] = tmp;
      end
    end else begin
      wb = lru_v[s] && dirty_l.exists(lru_l[s]);
      if (wb) begin
        wbq.push_back('{addr: lru_l[s], line: gline(lru_l[s])});
        dirty_l.delete(lru_l[s]);
      end
      lru_l[s] = mru[s];
      lru_v[s] = mru_v[s];
      mru[s]   = la;
      mru_v[s] = 1'b1;
      stall_exp = 2 + cur_lat + (wb ? cur_lat : 0);
      if (m_miss < CMAX) m_miss++;
    end
    if (m_hits < CMAX) m_hits++;
    e.data = gword(wa);
    e.h    = m_hits;
    e.m    = m_miss;
    sbq.push_back(e);
    if (wr) begin
      gmem[wa] = data;
      dirty_l[la] = 1'b1;
    end
  endtask

  // Driver: called just after a rising edge; returns once the request has been served
  task automatic do_req(input int unsigned addr, input bit wr, input logic [31:0] data);
    int stall_exp, n;
    bit served;
    model_access(addr, wr, data, stall_exp);
    p1_addr_i     = addr;
    p1_data_i     = data;
    p1_MemWrite_i = wr;
    p1_MemRead_i  = !wr;
    n = 0;
    served = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (!p1_stall_o) begin
        served = 1'b1;
        break;
      end
      n++;
    end
    check("served_within_budget", served, 1);
    check("stall_cycles", n, stall_exp);
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT serves a request
  bit cnt_pending = 1'b0;
  int pend_h, pend_m;

  initial begin
    forever begin
      @(negedge clk_i);
      if (cnt_pending) begin
        check("hit_cnt", hit_cnt_o, pend_h);
        check("miss_cnt", miss_cnt_o, pend_m);
        cnt_pending = 1'b0;
      end
      if (rst_i && (p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL serve_without_expectation: addr %0h", p1_addr_i);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("p1_data", p1_data_o, e.data);
          pend_h = e.h;
          pend_m = e.m;
          cnt_pending = 1'b1;
        end
      end
    end
  end

  // Line memory responder
  int                busy, cnt;
  logic [ADDR_W-1:0] fill_log_addr;
  logic              fill_log_write;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    busy = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        mem_ack_i = 1'b0;
        busy = 0;
      end else begin
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
          busy = 0;
        end
        if (mem_enable_o && busy == 0) begin
          busy = 1;
          cnt  = cur_lat;
          if (mem_write_o) begin
            if (wbq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_writeback: addr %0h", mem_addr_o);
            end else begin
              wb_t w;
              w = wbq.pop_front();
              check("wb_addr", mem_addr_o, w.addr);
              check("wb_data", mem_data_o, w.line);
            end
            for (int k = 0; k < WORDS; k++) bmem[mem_addr_o / 4 + k] = mem_data_o[k*32 +: 32];
          end else begin
            fill_log_addr  = mem_addr_o;
            fill_log_write = mem_write_o;
          end
        end
        if (busy != 0 && !mem_ack_i) begin
          if (cnt > 1) cnt--;
          else begin
            if (!mem_write_o) mem_data_i = bline(mem_addr_o);
            mem_ack_i = 1'b1;
          end
        end
      end
    end
  end

  localparam int unsigned A = 32'h0000_0040;
  localparam int unsigned B = A + SETS * LINE_B;
  localparam int unsigned C = A + 2 * SETS * LINE_B;
  localparam int unsigned D = 32'h0000_1000;

  initial begin
    rst_i = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    cur_lat = 3;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("reset_stall", p1_stall_o, 0);
    check("reset_mem_enable", mem_enable_o, 0);
    check("reset_mem_write", mem_write_o, 0);
    check("reset_mem_addr", mem_addr_o, 0);
    check("reset_hit_cnt", hit_cnt_o, 0);
    check("reset_miss_cnt", miss_cnt_o, 0);
    check("reset_p1_data", p1_data_o, 0);
    @(posedge clk_i);
    #1;

    // Clean miss with L=3
    gmem[(A + 4) / 4] = 32'hDEADBEEF;
    bmem[(A + 4) / 4] = 32'hDEADBEEF;
    do_req(A + 4, 1'b0, 32'h0);
    check("fill_addr", fill_log_addr, A);
    check("fill_write", fill_log_write, 0);

    // Write hit then read back
    do_req(A + 4, 1'b1, 32'h12345678);
    do_req(A + 4, 1'b0, 32'h0);

    // A dirty, B more recent, C evicts A with write-back
    do_req(B, 1'b0, 32'h0);
    do_req(C + 8, 1'b0, 32'h0);
    do_req(B + 12, 1'b0, 32'h0);

    // Conflict pair alternation
    do_req(A, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) do_req((i % 2 == 0) ? A + 4 : B + 4, 1'b0, 32'h0);
    do_req(C, 1'b0, 32'h0);
    do_req(B, 1'b0, 32'h0);

    // Reset during FILL
    cur_lat = 12;
    p1_addr_i = D;
    p1_MemRead_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    #1;
    check("rst_fill_mem_enable", mem_enable_o, 0);
    check("rst_fill_stall", p1_stall_o, 0);
    check("rst_fill_hit_cnt", hit_cnt_o, 0);
    check("rst_fill_miss_cnt", miss_cnt_o, 0);
    sbq.delete();
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    cur_lat = 2;
    do_req(D, 1'b0, 32'h0);

    // Hit counter saturation
    for (int i = 0; i < (1 << CNT_W) + 5; i++) do_req(D + 4 * (i % WORDS), 1'b0, 32'h0);
    @(negedge clk_i);
    check("hit_cnt_saturated", hit_cnt_o, CMAX);
    @(posedge clk_i);
    #1;

    // Randomized traffic over a few tags and sets
    for (int i = 0; i < 300; i++) begin
      int unsigned addr;
      addr = $urandom_range(0, 3) * SETS * LINE_B + $urandom_range(0, 3) * LINE_B
             + $urandom_range(0, WORDS - 1) * 4;
      cur_lat = $urandom_range(1, 4);
      do_req(addr, $urandom_range(0, 1) == 1, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #0;
    end

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", sbq.size(), 0);
    check("writebacks_drained", wbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
